// File: rtl/gyruss_hs_arbiter.sv
// Work-RAM port arbiter between the main CPU and the high-score interface.
// The CPU is stalled at a bus-cycle boundary before the high-score side takes the RAM.
module gyruss_hs_arbiter #(
    parameter int unsigned AW            = 11,
    parameter int unsigned DRAIN_TIMEOUT = 255
) (
    input  logic          i_clk_49m,
    input  logic          i_reset,        // active-low, asynchronous
    input  logic          i_cpu_cen,
    input  logic          i_pause,
    input  logic          i_cpu_ram_cs,
    input  logic          i_cpu_ram_we,
    input  logic [AW-1:0] i_cpu_addr,
    input  logic [7:0]    i_cpu_din,
    output logic [7:0]    o_cpu_dout,
    output logic          o_cpu_hold,
    input  logic [AW-1:0] i_hs_address,
    input  logic [7:0]    i_hs_data_in,
    output logic [7:0]    o_hs_data_out,
    input  logic          i_hs_write,
    input  logic          i_hs_access,
    output logic [AW-1:0] o_ram_addr,
    output logic [7:0]    o_ram_din,
    output logic          o_ram_we,
    input  logic [7:0]    i_ram_dout
);

    typedef enum logic [1:0] {StIdle, StDrain, StGrant, StRelease} state_e;

    localparam logic [7:0] TimeoutCnt = 8'(DRAIN_TIMEOUT);

    state_e     r_state;
    state_e     w_state_d;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_d;
    logic       r_hold;
    logic       r_cpu_rd;
    logic       r_hs_rd;
    logic [7:0] r_cpu_dout;
    logic [7:0] r_hs_dout;
    logic       w_grant;
    logic       w_we;

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = 8'd0;
        case (r_state)
            StIdle: begin
                if (i_hs_access) w_state_d = StDrain;
            end
            StDrain: begin
                w_cnt_d = (r_cnt == TimeoutCnt) ? r_cnt : r_cnt + 8'd1;
                if (!i_hs_access) begin
                    w_state_d = StRelease;
                end else if (i_cpu_cen || i_pause || (r_cnt == TimeoutCnt)) begin
                    w_state_d = StGrant;
                end
            end
            StGrant: begin
                if (!i_hs_access) w_state_d = StRelease;
            end
            StRelease: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
        if (w_state_d != StDrain) w_cnt_d = 8'd0;
    end

    assign w_grant    = (r_state == StGrant);
    assign o_ram_addr = w_grant ? i_hs_address : i_cpu_addr;
    assign o_ram_din  = w_grant ? i_hs_data_in : i_cpu_din;

    // In DRAIN the CPU's in-flight bus cycle may still complete its write.
    always_comb begin
        w_we = 1'b0;
        case (r_state)
            StIdle, StDrain: w_we = i_cpu_ram_cs & i_cpu_ram_we & i_cpu_cen;
            StGrant:         w_we = i_hs_write;
            default:         w_we = 1'b0;
        endcase
    end

    assign o_ram_we = w_we & i_reset;

    always_ff @(posedge i_clk_49m or negedge i_reset) begin
        if (!i_reset) begin
            r_state    <= StIdle;
            r_cnt      <= 8'd0;
            r_hold     <= 1'b0;
            r_cpu_rd   <= 1'b0;
            r_hs_rd    <= 1'b0;
            r_cpu_dout <= 8'h00;
            r_hs_dout  <= 8'h00;
        end else begin
            r_state  <= w_state_d;
            r_cnt    <= w_cnt_d;
            r_hold   <= (w_state_d != StIdle);
            r_cpu_rd <= ~w_grant & i_cpu_ram_cs & ~i_cpu_ram_we;
            r_hs_rd  <= w_grant;
            // RAM data arrives one cycle after the address; capture it for the owner of that address.
            if (r_cpu_rd) r_cpu_dout <= i_ram_dout;
            if (r_hs_rd)  r_hs_dout  <= i_ram_dout;
        end
    end

    assign o_cpu_hold    = r_hold;
    assign o_cpu_dout    = r_cpu_dout;
    assign o_hs_data_out = r_hs_dout;

endmodule
